// File: rtl/signal_buffer_sequencer.sv
// ============================================================================
// Module  : signal_buffer_sequencer
// Purpose : Streams sample blocks into (capture) or out of (playback) port 2
//           of the 8192x16 dual-port signal buffer over a circular window.
// Revision: 1.0
// ============================================================================
`default_nettype none

module signal_buffer_sequencer #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [ADDR_W-1:0] address2,
    output logic              chipselect2,
    output logic              write2,
    output logic [DATA_W-1:0] writedata2,
    output logic [1:0]        byteenable2,
    input  logic [DATA_W-1:0] readdata2
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] c_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_W-1:0] c_ONE     = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CAPT = 2'd1;
    localparam logic [1:0] c_PLAY = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  w_len_clamped;
    logic [ADDR_W-1:0] w_addr;

    logic [DATA_W-1:0] r_skid0;
    logic [DATA_W-1:0] r_skid1;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;
    logic              r_inflight;

    logic              w_start_ok;
    logic              w_snk_hs;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_abort_now;
    logic [DATA_W-1:0] w_head;

    assign w_len_clamped = (length > c_MAX_LEN) ? c_MAX_LEN : length;
    // Address width truncation gives the modulo-8192 window wrap for free.
    assign w_addr        = r_base + r_idx[ADDR_W-1:0];
    assign w_start_ok    = (r_state == c_IDLE) && start && !abort;
    assign w_abort_now   = ((r_state == c_CAPT) || (r_state == c_PLAY)) && abort;
    assign w_snk_hs      = (r_state == c_CAPT) && snk_valid;
    assign w_pop         = (r_state == c_PLAY) && (r_occ != 2'd0) && src_ready;
    assign w_push        = (r_state == c_PLAY) && r_inflight;
    assign w_head        = r_rd_ptr ? r_skid1 : r_skid0;

    // Issue only if the returning word is guaranteed a free skid slot.
    assign w_issue = (r_state == c_PLAY) && (r_idx < r_len) &&
                     (({1'b0, r_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start_ok) begin
                    if (w_len_clamped == '0) begin
                        w_next_state = c_DONE;
                    end else begin
                        w_next_state = mode ? c_PLAY : c_CAPT;
                    end
                end
            end
            c_CAPT: begin
                if (abort) begin
                    w_next_state = c_IDLE;
                end else if (w_snk_hs && ((r_count + c_ONE) == r_len)) begin
                    w_next_state = c_DONE;
                end
            end
            c_PLAY: begin
                if (abort) begin
                    w_next_state = c_IDLE;
                end else if (w_pop && ((r_count + c_ONE) == r_len)) begin
                    w_next_state = c_DONE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        snk_ready   = 1'b0;
        src_valid   = 1'b0;
        src_data    = '0;
        chipselect2 = 1'b0;
        write2      = 1'b0;
        address2    = '0;
        writedata2  = '0;
        byteenable2 = 2'b11;
        count       = r_count;
        case (r_state)
            c_CAPT: begin
                busy      = 1'b1;
                snk_ready = 1'b1;
                if (w_snk_hs) begin
                    chipselect2 = 1'b1;
                    write2      = 1'b1;
                    address2    = w_addr;
                    writedata2  = snk_data;
                end
            end
            c_PLAY: begin
                busy      = 1'b1;
                src_valid = (r_occ != 2'd0);
                src_data  = (r_occ != 2'd0) ? w_head : '0;
                if (w_issue) begin
                    chipselect2 = 1'b1;
                    address2    = w_addr;
                end
            end
            c_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_count    <= '0;
            r_skid0    <= '0;
            r_skid1    <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
        end else if (w_start_ok) begin
            r_base     <= base;
            r_len      <= w_len_clamped;
            r_idx      <= '0;
            r_count    <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            if (w_snk_hs || w_issue) begin
                r_idx <= r_idx + c_ONE;
            end
            if (w_snk_hs || w_pop) begin
                r_count <= r_count + c_ONE;
            end
            if (w_abort_now) begin
                // Flush; any word still returning from memory is dropped.
                r_wr_ptr   <= 1'b0;
                r_rd_ptr   <= 1'b0;
                r_occ      <= 2'd0;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_push) begin
                    if (r_wr_ptr) begin
                        r_skid1 <= readdata2;
                    end else begin
                        r_skid0 <= readdata2;
                    end
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_signal_buffer_sequencer.sv
// ============================================================================
// Module  : tb_signal_buffer_sequencer
// Purpose : Directed self-checking bench with a port-2 buffer memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_signal_buffer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, mode;
    logic [12:0] base;
    logic [13:0] length;
    logic        busy, done;
    logic [13:0] count;
    logic [15:0] snk_data;
    logic        snk_valid, snk_ready;
    logic [15:0] src_data;
    logic        src_valid, src_ready;
    logic [12:0] address2;
    logic        chipselect2, write2;
    logic [15:0] writedata2;
    logic [1:0]  byteenable2;
    logic [15:0] readdata2;

    logic [15:0] mem [8192];
    logic        tb_we;
    logic [12:0] tb_addr;
    logic [15:0] tb_wd;

    int total = 0;
    int bad   = 0;

    signal_buffer_sequencer #(.ADDR_W(13), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .base(base), .length(length), .busy(busy), .done(done), .count(count),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .address2(address2), .chipselect2(chipselect2), .write2(write2),
        .writedata2(writedata2), .byteenable2(byteenable2), .readdata2(readdata2)
    );

    always #5 clk = ~clk;

    // Buffer port 2 with one-cycle read latency, plus a backdoor preload port.
    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_wd;
        end else if (chipselect2 && write2) begin
            mem[address2] <= writedata2;
        end
        if (chipselect2 && !write2) begin
            readdata2 <= mem[address2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Drives start in cycle 0; returns just after the edge that begins cycle 1.
    task automatic start_op(input logic m, input logic [12:0] b, input logic [13:0] l);
        next_cycle();
        start = 1'b1; mode = m; base = b; length = l;
        sample();
        next_cycle();
        start = 1'b0;
    endtask

    initial begin
        int acc;
        int iss;
        int acc_cyc;
        int wr;
        logic done_seen;
        logic prev_stall;
        logic [15:0] prev_data;

        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        base = '0; length = '0; snk_data = '0; snk_valid = 1'b0; src_ready = 1'b0;
        tb_we = 1'b0; tb_addr = '0; tb_wd = '0; readdata2 = '0;

        // Reset state
        next_cycle(); next_cycle();
        sample();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_snk_ready", 32'(snk_ready), 0);
        chk("rst_src_valid", 32'(src_valid), 0);
        chk("rst_cs", 32'(chipselect2), 0);
        chk("rst_write", 32'(write2), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_addr", 32'(address2), 0);
        chk("rst_be", 32'(byteenable2), 3);
        next_cycle();
        reset = 1'b0;

        // Capture base=100 length=4
        start_op(1'b0, 13'd100, 14'd4);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            snk_valid = 1'b1; snk_data = 16'(16'hA0 + i);
            sample();
            chk("cap_busy", 32'(busy), 1);
            chk("cap_write", 32'(write2), 1);
            chk("cap_addr", 32'(address2), 100 + i);
            chk("cap_wdata", 32'(writedata2), 16'hA0 + i);
        end
        next_cycle();
        sample();
        chk("cap_done", 32'(done), 1);
        chk("cap_busy_end", 32'(busy), 0);
        chk("cap_ready_end", 32'(snk_ready), 0);
        chk("cap_write_end", 32'(write2), 0);
        chk("cap_count", 32'(count), 4);
        next_cycle();
        snk_valid = 1'b0;
        sample();
        chk("cap_done_once", 32'(done), 0);
        chk("cap_count_hold", 32'(count), 4);
        for (int i = 0; i < 4; i++) chk("cap_mem", 32'(mem[100 + i]), 16'hA0 + i);

        // Preload playback windows
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            tb_we = 1'b1;
            if (i < 4) begin
                tb_addr = 13'((8190 + i) % 8192); tb_wd = 16'((8190 + i) % 8192);
            end else begin
                tb_addr = 13'(200 + i - 4); tb_wd = 16'(16'h5500 + i - 4);
            end
        end
        next_cycle();
        tb_we = 1'b0;

        // Wrap-around playback base=8190 length=4
        src_ready = 1'b1;
        start_op(1'b1, 13'd8190, 14'd4);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) next_cycle();
            sample();
            if (c <= 4) begin
                chk("wrap_cs", 32'(chipselect2), 1);
                chk("wrap_write", 32'(write2), 0);
                chk("wrap_addr", 32'(address2), (8190 + c - 1) % 8192);
            end else begin
                chk("wrap_cs_idle", 32'(chipselect2), 0);
            end
            if (c >= 3 && c <= 6) begin
                chk("wrap_valid", 32'(src_valid), 1);
                chk("wrap_data", 32'(src_data), (8190 + c - 3) % 8192);
            end else begin
                chk("wrap_valid_low", 32'(src_valid), 0);
            end
            chk("wrap_done", 32'(done), (c == 7) ? 1 : 0);
        end
        chk("wrap_count", 32'(count), 4);

        // Backpressure playback base=200 length=8
        acc = 0; iss = 0; acc_cyc = -1; done_seen = 1'b0; prev_stall = 1'b0; prev_data = '0;
        start_op(1'b1, 13'd200, 14'd8);
        for (int c = 1; c < 100 && !done_seen; c++) begin
            if (c > 1) next_cycle();
            src_ready = (c % 3 == 1);
            sample();
            if (chipselect2) iss++;
            if (prev_stall) chk("bp_stable", 32'(src_data), 32'(prev_data));
            if (src_valid && src_ready) begin
                chk("bp_data", 32'(src_data), 16'h5500 + acc);
                acc++;
                if (acc == 8) acc_cyc = c;
            end
            chk("bp_outstanding", (iss - acc <= 2) ? 1 : 0, 1);
            prev_stall = src_valid && !src_ready;
            prev_data = src_data;
            if (done) begin
                done_seen = 1'b1;
                chk("bp_done_cycle", c, acc_cyc + 1);
                chk("bp_count", 32'(count), 8);
            end
        end
        chk("bp_done_seen", 32'(done_seen), 1);
        chk("bp_accepted", acc, 8);
        chk("bp_issued", iss, 8);

        // length=0
        src_ready = 1'b1;
        start_op(1'b1, 13'd5, 14'd0);
        sample();
        chk("len0_done", 32'(done), 1);
        chk("len0_busy", 32'(busy), 0);
        chk("len0_cs", 32'(chipselect2), 0);
        chk("len0_count", 32'(count), 0);
        next_cycle();
        sample();
        chk("len0_done_once", 32'(done), 0);

        // Abort in cycle 3 of a length=16 capture
        start_op(1'b0, 13'd300, 14'd16);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) next_cycle();
            snk_valid = 1'b1; snk_data = 16'(16'hC000 + c); abort = (c == 3);
            sample();
            chk("ab_write", 32'(write2), 1);
            chk("ab_addr", 32'(address2), 299 + c);
        end
        next_cycle();
        abort = 1'b0;
        sample();
        chk("ab_busy", 32'(busy), 0);
        chk("ab_ready", 32'(snk_ready), 0);
        chk("ab_write_after", 32'(write2), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_count", 32'(count), 3);
        for (int c = 5; c <= 7; c++) begin
            next_cycle();
            sample();
            chk("ab_quiet_write", 32'(write2), 0);
            chk("ab_quiet_done", 32'(done), 0);
        end
        snk_valid = 1'b0;

        // Restart after abort: read back two captured words
        start_op(1'b1, 13'd300, 14'd2);
        sample();
        chk("ab_restart_busy", 32'(busy), 1);
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            sample();
            if (c == 3 || c == 4) chk("ab_rb_data", 32'(src_data), 16'hC000 + c - 2);
            chk("ab_rb_done", 32'(done), (c == 5) ? 1 : 0);
        end

        // abort and start together in IDLE: abort wins
        next_cycle();
        start = 1'b1; abort = 1'b1; mode = 1'b0; base = 13'd0; length = 14'd4;
        sample();
        next_cycle();
        start = 1'b0; abort = 1'b0;
        sample();
        chk("abst_busy", 32'(busy), 0);
        chk("abst_ready", 32'(snk_ready), 0);
        chk("abst_count", 32'(count), 2);

        // Asynchronous reset in the middle of playback
        src_ready = 1'b1;
        start_op(1'b1, 13'd200, 14'd8);
        sample();
        next_cycle(); sample();
        next_cycle(); sample();
        chk("mr_busy_pre", 32'(busy), 1);
        chk("mr_cs_pre", 32'(chipselect2), 1);
        chk("mr_valid_pre", 32'(src_valid), 1);
        #1 reset = 1'b1;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_valid", 32'(src_valid), 0);
        chk("mr_cs", 32'(chipselect2), 0);
        chk("mr_write", 32'(write2), 0);
        chk("mr_count", 32'(count), 0);
        next_cycle(); next_cycle();
        reset = 1'b0;
        start_op(1'b1, 13'd200, 14'd3);
        sample();
        chk("mr_again_busy", 32'(busy), 1);
        for (int c = 2; c <= 6; c++) begin
            next_cycle();
            sample();
            if (c >= 3 && c <= 5) chk("mr_again_data", 32'(src_data), 16'h5500 + c - 3);
            chk("mr_again_done", 32'(done), (c == 6) ? 1 : 0);
        end

        // length=9000 capture clamps to 8192
        wr = 0; done_seen = 1'b0;
        snk_valid = 1'b1; snk_data = 16'h1234;
        start_op(1'b0, 13'd0, 14'd9000);
        for (int c = 1; c < 8300 && !done_seen; c++) begin
            if (c > 1) next_cycle();
            sample();
            if (write2) wr++;
            if (done) begin
                done_seen = 1'b1;
                chk("clamp_done_cycle", c, 8193);
            end
        end
        snk_valid = 1'b0;
        chk("clamp_done_seen", 32'(done_seen), 1);
        chk("clamp_writes", wr, 8192);
        chk("clamp_count", 32'(count), 8192);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/signal_buffer_sequencer.md
# signal_buffer_sequencer

Sequences transfers between streaming sample interfaces and the second port (s2) of the 8192×16 dual-port signal buffer, while the HPS keeps port s1.
- Capture mode: writes a block of incoming samples into the buffer.
- Playback mode: reads a block out of the buffer as a stream.
- Both modes use a programmable circular window (base, length) and report completion with a done pulse.

## Interface
- ADDR_W, 13, buffer word-address width (depth 2^ADDR_W = 8192)
- DATA_W, 16, sample width
- clk  in  1  sole clock; drives buffer clock1
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  terminates the current operation
- mode  in  1  0 = capture, 1 = playback; sampled with start
- base  in  ADDR_W  first buffer address; sampled with start
- length  in  ADDR_W+1  word count, 0..8192; sampled with start
- busy  out  1  high in CAPT/PLAY
- done  out  1  one-cycle completion pulse
- count  out  ADDR_W+1  words transferred in current/last operation
- snk_data  in  DATA_W  capture sample
- snk_valid  in  1  capture sample valid
- snk_ready  out  1  capture ready
- src_data  out  DATA_W  playback sample
- src_valid  out  1  playback valid
- src_ready  in  1  playback ready
- address2  out  ADDR_W  buffer port-2 address
- chipselect2  out  1  buffer port-2 select
- write2  out  1  buffer port-2 write
- writedata2  out  DATA_W  buffer port-2 write data
- byteenable2  out  2  tied to 2'b11
- readdata2  in  DATA_W  buffer port-2 read data; valid the cycle after the address is presented

## Operation
- States: IDLE, CAPT, PLAY, DONE.
- Reset values: state IDLE; busy, done, snk_ready, src_valid, chipselect2, write2 = 0; count, address2, writedata2, src_data = 0.
- IDLE, start=1:
  - Latch mode, base, and length (clamp length > 8192 to 8192).
  - Clear count and the word pointer idx.
  - length=0 → DONE with no memory access.
  - Otherwise go to CAPT (mode=0) or PLAY (mode=1).
- start outside IDLE: ignored.
- Address arithmetic: address2 = (base + idx) mod 8192, so a window that crosses 8191 wraps to 0.
- CAPT:
  - snk_ready=1.
  - On each snk_valid & snk_ready: chipselect2 = write2 = 1, writedata2 = snk_data, address2 = base + idx, all combinational from the handshake. Then idx and count increment.
  - After the handshake that makes count == length, snk_ready drops in the next cycle → DONE.
- PLAY:
  - write2=0.
  - A read (chipselect2=1, address2 = base + idx, idx++) is issued whenever idx < length and (skid occupancy + reads in flight − pop this cycle) < 2.
  - readdata2 is captured into a 2-entry skid buffer one cycle after issue. src_valid/src_data come from the skid head.
  - count increments on each src_valid & src_ready.
  - When count == length and the skid is empty → DONE.
  - Order is preserved; no word is dropped or duplicated under any src_ready pattern.
- DONE: done=1 for exactly one cycle, busy=0 → IDLE. count holds its final value until the next accepted start.
- abort=1 in CAPT/PLAY:
  - Next cycle: state IDLE, skid flushed, src_valid=0, snk_ready=0, no further memory access.
  - done is not pulsed; count holds the words completed so far.
  - Data returning from an in-flight read is discarded.
- abort in IDLE/DONE: no effect. abort and start asserted together in IDLE: abort wins, start ignored.

## Timing
- Start accepted in cycle 0; busy=1 from cycle 1.
- Capture: first write possible in cycle 1. Throughput is 1 word/cycle while snk_valid=1.
- Playback: first read address in cycle 1, readdata2 in cycle 2, src_valid=1 in cycle 3.
- With src_ready held high, playback runs 1 word/cycle with no bubbles.
- With src_ready low, reads stop once 2 words are held or in flight. src_data is stable while src_valid & !src_ready.
- done is asserted the cycle after the last transfer (capture) or after the last src acceptance (playback). busy falls in the same cycle done rises.
- Reset is asynchronous mid-operation: all outputs return to reset values immediately. No write2 glitch is produced after reset asserts.

## Test plan
- Capture, base=100, length=4, snk_valid=1 with data 0xA0..0xA3 → writes to addresses 100..103 in cycles 1..4, done in cycle 5, count=4.
- Wrap-around playback, base=8190, length=4, buffer preloaded with addr→addr value → src yields 0x1FFE, 0x1FFF, 0x0000, 0x0001 in cycles 3..6; address2 sequence 8190, 8191, 0, 1.
- Playback backpressure, length=8, src_ready toggling 1,0,0,1,… → src order intact, no duplicates, chipselect2 never leaves more than 2 words outstanding, done after the 8th acceptance.
- length=0 and length=9000 → length=0 gives done in cycle 1 with no chipselect2; length=9000 is clamped, transfers 8192 words, final count=8192.
- abort in cycle 3 of a length=16 capture with snk_valid=1 → IDLE in cycle 4, count=3, no done pulse, no write after cycle 3; a subsequent start is accepted.
- reset asserted mid-PLAY → busy, src_valid, chipselect2 = 0 asynchronously; after release, start runs a normal playback.
